// File: rtl/synth_ui_pkg.sv
// Shared UI types: per-channel toggle FSM state encoding and state decode helpers.
// Pure declarations, no clocked logic.
package synth_ui_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    ARM_OFF = 2'd2,
    ARM_ON  = 2'd3
  } state_t;

  function automatic logic is_on(input state_t s);
    return (s == ON) || (s == ARM_OFF);
  endfunction

  function automatic logic is_arm(input state_t s);
    return (s == ARM_ON) || (s == ARM_OFF);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level; emits one-cycle press/release pulses the cycle after db changes.
// Free-running, no backpressure; press pulses are withheld until the sync stage has been seen released after reset.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise,
  output logic fall
);

  localparam int   CW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic REL   = (BTN_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;
  logic [1:0]    fill;
  logic          primed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= REL;
      s     <= REL;
    end else begin
      sync1 <= btn;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db  <= REL;
      cnt <= '0;
    end else if (s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A button held through reset must be seen released before its next press counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill   <= '0;
      primed <= 1'b0;
      db_q   <= REL;
    end else begin
      fill <= {fill[0], 1'b1};
      db_q <= db;
      if (fill[1] && (s == REL)) begin
        primed <= 1'b1;
      end
    end
  end

  assign rise = (db != db_q) && (db != REL) && primed;
  assign fall = (db != db_q) && (db == REL);

endmodule

// File: rtl/btn_toggle_bank.sv
// Bank of debounced buttons driving release-triggered toggle FSMs with long-press detect and optional radio grouping.
// z changes DEBOUNCE_CYCLES+2 edges after a raw release is first sampled; no backpressure, events are single-cycle pulses.
module btn_toggle_bank
  import synth_ui_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int RADIO_MODE      = 0,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] z,
  output logic [NUM_CH-1:0] toggle_evt,
  output logic [NUM_CH-1:0] long_evt
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] go_on;
  logic [NUM_CH-1:0] win;
  logic [NUM_CH-1:0] toggle_nxt;
  logic [NUM_CH-1:0] long_nxt;

  state_t        state     [NUM_CH];
  state_t        state_nxt [NUM_CH];
  logic [HW-1:0] hold      [NUM_CH];
  logic [HW-1:0] hold_nxt  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .rise (press[i]),
      .fall (rel[i])
    );
  end

  always_comb begin
    go_on = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      go_on[i] = (state[i] == ARM_ON) && rel[i] && (hold[i] != HOLD_MAX);
    end
  end

  // Two's-complement trick isolates the lowest-index short release.
  assign win = go_on & (-go_on);

  always_comb begin
    toggle_nxt = '0;
    long_nxt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      hold_nxt[i]  = '0;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      case (state[i])
        OFF:     if (press[i]) state_nxt[i] = ARM_ON;
        ON:      if (press[i]) state_nxt[i] = ARM_OFF;
        ARM_ON:  if (rel[i])   state_nxt[i] = go_on[i] ? ON : OFF;
        ARM_OFF: begin
          if (rel[i]) begin
            state_nxt[i]  = OFF;
            toggle_nxt[i] = (hold[i] != HOLD_MAX);
          end
        end
        default: state_nxt[i] = OFF;
      endcase
      if (go_on[i]) begin
        toggle_nxt[i] = 1'b1;
      end
    end

    if ((RADIO_MODE != 0) && (|go_on)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!win[i]) begin
          state_nxt[i]  = OFF;
          toggle_nxt[i] = is_on(state[i]) && !(rel[i] && (hold[i] == HOLD_MAX));
        end
      end
    end

    // Hold time restarts on every entry into an ARM state and saturates there.
    for (int i = 0; i < NUM_CH; i++) begin
      if (is_arm(state[i]) && is_arm(state_nxt[i])) begin
        hold_nxt[i] = (hold[i] == HOLD_MAX) ? hold[i] : hold[i] + HW'(1);
        long_nxt[i] = (hold[i] == HOLD_PRE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= OFF;
        hold[i]  <= '0;
      end
      toggle_evt <= '0;
      long_evt   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        hold[i]  <= hold_nxt[i];
      end
      toggle_evt <= toggle_nxt;
      long_evt   <= long_nxt;
    end
  end

  always_comb begin
    z = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      z[i] = is_on(state[i]);
    end
  end

endmodule

// File: tb/tb_btn_toggle_bank.sv
// Directed bench: two banks (independent and radio) with short debounce/long windows, checked by immediate assertions.
module tb_btn_toggle_bank;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn0, btn1;
  logic [3:0] z0, t0, l0;
  logic [3:0] z1, t1, l1;

  int errors = 0;
  int checks = 0;
  int tg0[4], lg0[4], tg1[4], lg1[4];

  btn_toggle_bank #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .RADIO_MODE(0), .BTN_ACTIVE_LOW(1)
  ) dut0 (
    .clk(clk), .reset(rst_n), .btn(btn0), .z(z0), .toggle_evt(t0), .long_evt(l0)
  );

  btn_toggle_bank #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .RADIO_MODE(1), .BTN_ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .reset(rst_n), .btn(btn1), .z(z1), .toggle_evt(t1), .long_evt(l1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_counts();
    for (int c = 0; c < 4; c++) begin
      tg0[c] = 0; lg0[c] = 0; tg1[c] = 0; lg1[c] = 0;
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge and tallying event pulses.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        tg0[c] += int'(t0[c]);
        lg0[c] += int'(l0[c]);
        tg1[c] += int'(t1[c]);
        lg1[c] += int'(l1[c]);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sum4(input int a0, input int a1, input int a2, input int a3);
    return a0 + a1 + a2 + a3;
  endfunction

  initial begin
    btn0  = 4'hF;
    btn1  = 4'hF;
    rst_n = 1'b0;
    clr_counts();
    tick(3);
    chk("reset_z0", int'(z0), 0);
    chk("reset_tog0", int'(t0), 0);
    chk("reset_long0", int'(l0), 0);
    chk("reset_z1", int'(z1), 0);
    rst_n = 1'b1;
    tick(5);

    // Short tap on ch0: toggles on release, exactly DEBOUNCE+2 edges after release sampled.
    clr_counts();
    btn0[0] = 1'b0;
    tick(10);
    chk("press_no_toggle", int'(z0), 0);
    btn0[0] = 1'b1;
    tick(6);
    chk("tap_latency_minus1", int'(z0), 0);
    tick(1);
    chk("tap_on_z", int'(z0), 4'b0001);
    chk("tap_on_evt", int'(t0), 4'b0001);
    tick(5);
    chk("tap_on_evt_once", tg0[0], 1);

    clr_counts();
    btn0[0] = 1'b0;
    tick(10);
    btn0[0] = 1'b1;
    tick(7);
    chk("tap_off_z", int'(z0), 0);
    chk("tap_off_evt_once", tg0[0], 1);

    // Glitches of 3 cycles are rejected.
    clr_counts();
    for (int g = 0; g < 5; g++) begin
      btn0[1] = 1'b0;
      tick(3);
      btn0[1] = 1'b1;
      tick(5);
    end
    tick(10);
    chk("glitch_z", int'(z0), 0);
    chk("glitch_tog", sum4(tg0[0], tg0[1], tg0[2], tg0[3]), 0);
    chk("glitch_long", sum4(lg0[0], lg0[1], lg0[2], lg0[3]), 0);

    // A press exactly DEBOUNCE_CYCLES long is the shortest accepted.
    btn0[1] = 1'b0;
    tick(4);
    btn0[1] = 1'b1;
    tick(12);
    chk("min_press_z", int'(z0), 4'b0010);
    btn0[1] = 1'b0;
    tick(10);
    btn0[1] = 1'b1;
    tick(8);
    chk("min_press_off", int'(z0), 0);

    // Long press on ch2 while on: one long_evt, release turns it off silently.
    btn0[2] = 1'b0;
    tick(10);
    btn0[2] = 1'b1;
    tick(8);
    chk("ch2_on", int'(z0), 4'b0100);
    clr_counts();
    btn0[2] = 1'b0;
    tick(26);
    chk("long_not_yet", lg0[2], 0);
    tick(1);
    chk("long_pulse", int'(l0), 4'b0100);
    tick(13);
    chk("long_hold_z", int'(z0), 4'b0100);
    chk("long_single", lg0[2], 1);
    btn0[2] = 1'b1;
    tick(10);
    chk("long_release_z", int'(z0), 0);
    chk("long_release_no_tog", tg0[2], 0);
    chk("long_release_single", lg0[2], 1);

    // Radio bank: ch0 on, then tap ch3 steals it.
    btn1[0] = 1'b0;
    tick(10);
    btn1[0] = 1'b1;
    tick(7);
    chk("radio_ch0_on", int'(z1), 4'b0001);
    btn1[3] = 1'b0;
    tick(10);
    chk("radio_arm_holds", int'(z1), 4'b0001);
    btn1[3] = 1'b1;
    tick(6);
    chk("radio_pre", int'(z1), 4'b0001);
    tick(1);
    chk("radio_steal_z", int'(z1), 4'b1000);
    chk("radio_steal_evt", int'(t1), 4'b1001);

    // Simultaneous releases on ch1 and ch2: lowest index wins.
    btn1[1] = 1'b0;
    btn1[2] = 1'b0;
    tick(10);
    btn1[1] = 1'b1;
    btn1[2] = 1'b1;
    tick(7);
    chk("radio_tie_z", int'(z1), 4'b0010);
    chk("radio_tie_evt", int'(t1), 4'b1010);

    // Reset while ch0 is armed; the still-held button is ignored afterwards.
    btn0[0] = 1'b0;
    tick(10);
    chk("pre_reset_armed", int'(z0), 0);
    rst_n = 1'b0;
    tick(2);
    chk("mid_reset_z0", int'(z0), 0);
    chk("mid_reset_z1", int'(z1), 0);
    rst_n = 1'b1;
    clr_counts();
    tick(20);
    chk("held_after_reset", int'(z0), 0);
    btn0[0] = 1'b1;
    tick(12);
    chk("held_release_ignored", int'(z0), 0);
    chk("held_release_no_evt", tg0[0], 0);
    btn0[0] = 1'b0;
    tick(10);
    btn0[0] = 1'b1;
    tick(7);
    chk("repress_toggles", int'(z0), 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_toggle_bank.md
BTN_TOGGLE_BANK -- requirements
Module: btn_toggle_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent button/toggle channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles required before a debounced level change (>=2).
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, meaning debounced hold length that qualifies as a long press (>DEBOUNCE_CYCLES).
REQ-004 SHALL have parameter RADIO_MODE, default 0, meaning 0 = independent toggles and 1 = at most one channel on.
REQ-005 SHALL have parameter BTN_ACTIVE_LOW, default 1, meaning a raw 0 is "pressed".
REQ-006 SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-007 SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 SHALL have port btn, input, NUM_CH bits, meaning raw asynchronous button levels, one per channel.
REQ-009 SHALL have port z, output, NUM_CH bits, meaning per-channel play/on state.
REQ-010 SHALL have port toggle_evt, output, NUM_CH bits, meaning a one-cycle pulse when the channel's z changes due to a short press.
REQ-011 SHALL have port long_evt, output, NUM_CH bits, meaning a one-cycle pulse when the channel's hold reaches LONG_CYCLES.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer; the second stage is s[i].
REQ-013 Debounce SHALL work as follows: keep db[i] and cnt[i]; cnt clears whenever s==db; otherwise cnt increments; when cnt==DEBOUNCE_CYCLES-1 and s!=db, db takes s and cnt clears.
REQ-014 A raw change first sampled at edge 0 and held stable SHALL change db at edge DEBOUNCE_CYCLES+1; any shorter glitch SHALL leave db unchanged.
REQ-015 Each channel SHALL run a 4-state FSM: OFF, ARM_ON, ON, ARM_OFF; z[i]=1 exactly in ON and ARM_OFF.
REQ-016 FSM transitions SHALL be: OFF->ARM_ON on press; ON->ARM_OFF on press; ARM_ON->ON on release; ARM_OFF->OFF on release; otherwise hold.
REQ-017 Toggling SHALL occur on release, never on press; z[i] SHALL change at edge DEBOUNCE_CYCLES+2 after the raw release is first sampled.
REQ-018 The hold counter SHALL count cycles spent in ARM_ON/ARM_OFF, saturate at LONG_CYCLES, and clear on entering OFF or ON.
REQ-019 long_evt[i] SHALL pulse for one cycle on the cycle the hold counter reaches LONG_CYCLES.
REQ-020 Release after a long press SHALL go to OFF from either ARM state, with no toggle_evt pulse.
REQ-021 toggle_evt[i] SHALL pulse for one cycle concurrent with a short-press ARM_ON->ON or ARM_OFF->OFF transition.
REQ-022 With RADIO_MODE=1, any ARM_ON->ON transition on channel i SHALL force every other channel to OFF in the same edge and clear its hold counter; only channels whose z actually falls receive a toggle_evt pulse.
REQ-023 With RADIO_MODE=1 and simultaneous ARM_ON->ON transitions, the lowest index SHALL win; the others go to OFF with no toggle_evt pulse.
REQ-024 Holding a button indefinitely SHALL keep the channel in its ARM state with z unchanged, and SHALL NOT pulse long_evt again.

Reset
REQ-025 On reset low, all FSMs SHALL go to OFF; z, toggle_evt and long_evt SHALL be 0; all counters SHALL be 0; synchronizers and db SHALL be at the released level.
REQ-026 Reset asserted mid-press SHALL discard the press; after deassertion a still-held button SHALL NOT register until it is released and pressed again.

Structure
REQ-027 The FSM state typedef and its encodings (OFF=0, ON=1, ARM_OFF=2, ARM_ON=3) SHALL live in shared package synth_ui_pkg.
REQ-028 The synchronizer and debounce logic SHALL be a sub-module btn_debounce, instantiated NUM_CH times; the FSM and radio arbitration stay in btn_toggle_bank.

Verification (NUM_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Release reset; tap ch0 for 10 cycles -> z=4'b0001 at edge 6 after release; toggle_evt[0] pulses once; tap again -> z=0.
REQ-030 Apply 3-cycle glitches on ch1, repeated 5 times -> z, toggle_evt and long_evt stay 0.
REQ-031 Hold ch2 for 40 cycles with ch2 on -> long_evt[2] single pulse; after release z[2]=0 with no toggle_evt.
REQ-032 With RADIO_MODE=1, ch0 on; tap ch3 -> z=4'b1000 in one edge; toggle_evt=4'b1001.
REQ-033 With RADIO_MODE=1, release ch1 and ch2 on the same cycle -> z=4'b0010.
REQ-034 Assert reset while ch0 is held in ARM_ON -> z=0; after deassertion the held button is ignored until it is re-pressed.
